cache_mem_ctrl: RTL and testbench
=================================

CACHE_MEM_CTRL -- requirements
Module: cache_mem_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning the maximum number of cycles a grant is held without RAM ACCESS.
REQ-002 SHALL have ports CLK (in, 1, clock) and nRST (in, 1, reset); reset nRST, asynchronous, active-low; clock CLK.
REQ-003 SHALL have iREN (in, 1, icache read request), iaddr (in, 32, icache word address), iwait (out, 1, icache stall), iload (out, 32, icache read data).
REQ-004 SHALL have dREN (in, 1, dcache read request), dWEN (in, 1, dcache write request), daddr (in, 32, address), dstore (in, 32, write data), dwait (out, 1, dcache stall), dload (out, 32, dcache read data).
REQ-005 SHALL have ramREN (out, 1), ramWEN (out, 1), ramaddr (out, 32), ramstore (out, 32), ramload (in, 32), ramstate (in, 2: FREE=0, BUSY=1, ACCESS=2, ERROR=3).
REQ-006 SHALL have tmo_err (out, 1, sticky timeout flag).

Function
REQ-007 SHALL implement a registered FSM with states IDLE, DGRANT, IGRANT.
REQ-008 IDLE: SHALL go to DGRANT if dREN|dWEN; else to IGRANT if iREN; else stay in IDLE. Dcache has fixed priority.
REQ-009 DGRANT/IGRANT: SHALL return to IDLE on the first cycle ramstate==ACCESS. One IDLE cycle always separates transactions.
REQ-010 DGRANT/IGRANT: if the granted requester deasserts its request, SHALL return to IDLE next cycle and give no acknowledge.
REQ-011 ramWEN SHALL equal (state==DGRANT & dWEN); ramREN SHALL equal (state==DGRANT & dREN & !dWEN) | (state==IGRANT & iREN). dWEN wins over dREN.
REQ-012 ramaddr SHALL be daddr in DGRANT, iaddr in IGRANT, 0 in IDLE; ramstore SHALL be dstore at all times.
REQ-013 dwait SHALL be 0 only when state==DGRANT & ramstate==ACCESS; iwait SHALL be 0 only when state==IGRANT & ramstate==ACCESS; both 1 otherwise, including in IDLE.
REQ-014 dload and iload SHALL be combinational pass-throughs of ramload.
REQ-015 ramstate ERROR SHALL be treated as BUSY (the request is held and retried).
REQ-016 A 16-bit wait counter SHALL clear on entry to a grant state and increment each grant cycle without ACCESS.
REQ-017 When the wait counter reaches TIMEOUT-1 without ACCESS, the FSM SHALL go to IDLE, set tmo_err, and give no acknowledge. tmo_err clears only on reset.
REQ-018 If ACCESS and timeout occur in the same cycle, ACCESS SHALL win: acknowledge given, tmo_err unchanged.
REQ-019 If a new dcache request arrives while IGRANT is active, the icache transaction SHALL complete first; no preemption.

Reset
REQ-020 On nRST low, the FSM SHALL go to IDLE immediately and the wait counter and tmo_err SHALL clear.
REQ-021 During reset, ramREN=0, ramWEN=0, ramaddr=0, iwait=1, dwait=1; a reset mid-transaction SHALL abort it with no acknowledge.

Configuration
REQ-022 Macro MEMCTRL_STATS_EN: when defined, SHALL add outputs icount and dcount (32 bits each), reset to 0, each incremented on every acknowledged transaction for its requester, wrapping at 2^32.
REQ-023 Without MEMCTRL_STATS_EN, these ports and their counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-024 The ramstate encoding (ramstate_t) and word_t SHALL come from the shared cpu_types_pkg; the FSM state enum SHALL be local to the module.
REQ-025 SHALL be a single module with no sub-modules; the wait counter is inline.

Verification
REQ-026 dREN=1, daddr=0x40, RAM reaches ACCESS after 3 BUSY cycles with ramload=0xDEADBEEF -> dwait=0 for exactly 1 cycle, dload=0xDEADBEEF, iwait stays 1.
REQ-027 iREN and dWEN asserted in the same cycle in IDLE, dstore=0x1234 -> DGRANT first with ramWEN=1 and ramstore=0x1234; then IDLE, then IGRANT.
REQ-028 IGRANT active and dREN raised mid-transaction -> icache acknowledged first; DGRANT entered two cycles after the icache ACCESS.
REQ-029 TIMEOUT=8, ramstate held at ERROR -> FSM returns to IDLE after 8 grant cycles, tmo_err=1, no acknowledge; tmo_err stays 1 until nRST.
REQ-030 nRST pulsed low during DGRANT -> ramREN and ramWEN drop to 0 asynchronously; after release, state is IDLE and, with MEMCTRL_STATS_EN, dcount=0.
REQ-031 With MEMCTRL_STATS_EN, 5 dcache and 3 icache completed accesses -> dcount=5, icount=3.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: the RAM handshake state encoding and the machine word.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/cache_mem_ctrl_if.sv
// Cache-side and RAM-side bus of the memory controller.
// master = controller view (drives the RAM), slave = environment view (caches + RAM).
interface cache_mem_ctrl_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;

    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/cache_mem_ctrl.sv
// Arbiter between icache and dcache for a single RAM port, with grant timeout.
// Optional macro MEMCTRL_STATS_EN adds per-requester acknowledged-transaction counters.
//
// state  | meaning
// IDLE   | no grant; one IDLE cycle always separates transactions
// DGRANT | dcache owns the RAM until ACCESS, request drop or timeout
// IGRANT | icache owns the RAM until ACCESS, request drop or timeout
module cache_mem_ctrl
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic CLK,
    input  logic nRST,
    cache_mem_ctrl_if.master bus,
    output logic tmo_err
`ifdef MEMCTRL_STATS_EN
    ,
    output word_t icount,
    output word_t dcount
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state, next_state;
    logic [15:0] wait_cnt;
    logic        access;
    logic        tmo_hit;

    // ERROR is deliberately not special-cased: only ACCESS ends a grant.
    assign access = (bus.ramstate == ACCESS);

    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        tmo_hit    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.dREN || bus.dWEN) next_state = DGRANT;
                else if (bus.iREN)        next_state = IGRANT;
            end
            DGRANT: begin
                if (access)                          next_state = IDLE;
                else if (!(bus.dREN || bus.dWEN))    next_state = IDLE;
                else if (wait_cnt == TMO_LAST) begin
                    next_state = IDLE;
                    tmo_hit    = 1'b1;
                end
            end
            IGRANT: begin
                if (access)                    next_state = IDLE;
                else if (!bus.iREN)            next_state = IDLE;
                else if (wait_cnt == TMO_LAST) begin
                    next_state = IDLE;
                    tmo_hit    = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.ramREN  = 1'b0;
        bus.ramWEN  = 1'b0;
        bus.ramaddr = '0;
        bus.dwait   = 1'b1;
        bus.iwait   = 1'b1;
        case (state)
            DGRANT: begin
                bus.ramWEN  = bus.dWEN;
                bus.ramREN  = bus.dREN & ~bus.dWEN;
                bus.ramaddr = bus.daddr;
                bus.dwait   = ~access;
            end
            IGRANT: begin
                bus.ramREN  = bus.iREN;
                bus.ramaddr = bus.iaddr;
                bus.iwait   = ~access;
            end
            default: ;
        endcase
    end

    assign bus.ramstore = bus.dstore;
    assign bus.dload    = bus.ramload;
    assign bus.iload    = bus.ramload;

    // Held at zero in IDLE, so every grant starts counting from zero.
    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST)                          wait_cnt <= '0;
        else if (state == IDLE)             wait_cnt <= '0;
        else if (!access)                   wait_cnt <= wait_cnt + 16'd1;
    end

    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST)        tmo_err <= 1'b0;
        else if (tmo_hit) tmo_err <= 1'b1;
    end

`ifdef MEMCTRL_STATS_EN
    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            icount <= '0;
            dcount <= '0;
        end else begin
            if (state == DGRANT && access) dcount <= dcount + 32'd1;
            if (state == IGRANT && access) icount <= icount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Directed bench for cache_mem_ctrl: expected acknowledges are queued by the
// stimulus and checked by an independent monitor whenever dwait/iwait drops.
module tb_cache_mem_ctrl;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic nRST;
    logic tmo_err;
`ifdef MEMCTRL_STATS_EN
    word_t icount, dcount;
`endif

    cache_mem_ctrl_if bus ();

    cache_mem_ctrl #(.TIMEOUT(8)) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .bus     (bus),
        .tmo_err (tmo_err)
`ifdef MEMCTRL_STATS_EN
        ,
        .icount  (icount),
        .dcount  (dcount)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit    is_d;
        word_t data;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   nd_exp = 0;
    int   ni_exp = 0;

    function automatic void chk32(string nm, word_t act, word_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void chk1(string nm, logic act, logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endfunction

    // Monitor: every acknowledge must match the head of the scoreboard.
    always @(negedge CLK) begin
        if (nRST === 1'b1 && (bus.dwait === 1'b0 || bus.iwait === 1'b0)) begin
            tests++;
            if (bus.dwait === 1'b0 && bus.iwait === 1'b0) begin
                fails++;
                $display("FAIL dual_ack: both dwait and iwait low at %0t", $time);
            end else if (sbq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_ack: dwait=%b iwait=%b with empty scoreboard at %0t",
                         bus.dwait, bus.iwait, $time);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (e.is_d && bus.dwait !== 1'b0) begin
                    fails++;
                    $display("FAIL ack_owner: got icache ack expected dcache ack at %0t", $time);
                end else if (!e.is_d && bus.iwait !== 1'b0) begin
                    fails++;
                    $display("FAIL ack_owner: got dcache ack expected icache ack at %0t", $time);
                end else if (e.is_d && bus.dload !== e.data) begin
                    fails++;
                    $display("FAIL dload: got 0x%08h expected 0x%08h at %0t", bus.dload, e.data, $time);
                end else if (!e.is_d && bus.iload !== e.data) begin
                    fails++;
                    $display("FAIL iload: got 0x%08h expected 0x%08h at %0t", bus.iload, e.data, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_ack(input bit is_d, input word_t data);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        sbq.push_back(e);
        if (is_d) nd_exp++;
        else      ni_exp++;
    endtask

    task automatic d_txn(input bit wen, input word_t addr, input word_t store,
                         input word_t load, input int nbusy);
        bus.dWEN     = wen;
        bus.dREN     = ~wen;
        bus.daddr    = addr;
        bus.dstore   = store;
        bus.ramstate = BUSY;
        tick();
        chk1("dgrant_ramWEN", bus.ramWEN, wen);
        chk1("dgrant_ramREN", bus.ramREN, ~wen);
        chk32("dgrant_ramaddr", bus.ramaddr, addr);
        chk1("dgrant_iwait", bus.iwait, 1'b1);
        repeat (nbusy - 1) tick();
        bus.ramstate = ACCESS;
        bus.ramload  = load;
        push_ack(1'b1, load);
        tick();
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.ramstate = FREE;
        chk1("d_after_ack_dwait", bus.dwait, 1'b1);
    endtask

    task automatic i_txn(input word_t addr, input word_t load, input int nbusy);
        bus.iREN     = 1'b1;
        bus.iaddr    = addr;
        bus.ramstate = BUSY;
        tick();
        chk1("igrant_ramREN", bus.ramREN, 1'b1);
        chk1("igrant_ramWEN", bus.ramWEN, 1'b0);
        chk32("igrant_ramaddr", bus.ramaddr, addr);
        repeat (nbusy - 1) tick();
        bus.ramstate = ACCESS;
        bus.ramload  = load;
        push_ack(1'b0, load);
        tick();
        bus.iREN     = 1'b0;
        bus.ramstate = FREE;
        chk1("i_after_ack_ramREN", bus.ramREN, 1'b0);
    endtask

    word_t dv_addr [5] = '{32'h0000_1000, 32'h0000_1004, 32'h0000_1008, 32'h0000_100C, 32'h0000_1010};
    word_t dv_data [5] = '{32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000, 32'h5555_0000};
    bit    dv_wen  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    word_t iv_addr [3] = '{32'h0000_2000, 32'h0000_2004, 32'h0000_2008};
    word_t iv_data [3] = '{32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003};

    initial begin
        nRST         = 1'b0;
        bus.iREN     = 1'b0;
        bus.iaddr    = '0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramload  = '0;
        bus.ramstate = FREE;

        #12;
        chk1("rst_ramREN", bus.ramREN, 1'b0);
        chk1("rst_ramWEN", bus.ramWEN, 1'b0);
        chk32("rst_ramaddr", bus.ramaddr, 32'h0);
        chk1("rst_iwait", bus.iwait, 1'b1);
        chk1("rst_dwait", bus.dwait, 1'b1);
        chk1("rst_tmo_err", tmo_err, 1'b0);
        @(posedge CLK);
        #1 nRST = 1'b1;
        tick();

        // dcache read, three BUSY cycles before ACCESS
        d_txn(1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 3);

        // simultaneous dcache write and icache read: dcache first, IDLE, then icache
        bus.dWEN     = 1'b1;
        bus.dstore   = 32'h0000_1234;
        bus.daddr    = 32'h0000_0100;
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h0000_0200;
        bus.ramstate = BUSY;
        tick();
        chk1("prio_ramWEN", bus.ramWEN, 1'b1);
        chk1("prio_ramREN", bus.ramREN, 1'b0);
        chk32("prio_ramstore", bus.ramstore, 32'h0000_1234);
        chk32("prio_ramaddr", bus.ramaddr, 32'h0000_0100);
        bus.ramstate = ACCESS;
        bus.ramload  = 32'hA5A5_0001;
        push_ack(1'b1, 32'hA5A5_0001);
        tick();
        bus.dWEN     = 1'b0;
        bus.ramstate = BUSY;
        chk1("gap_ramREN", bus.ramREN, 1'b0);
        chk32("gap_ramaddr", bus.ramaddr, 32'h0);
        chk1("gap_iwait", bus.iwait, 1'b1);
        chk32("idle_ramstore", bus.ramstore, 32'h0000_1234);
        tick();
        chk1("prio_igrant_ramREN", bus.ramREN, 1'b1);
        chk32("prio_igrant_ramaddr", bus.ramaddr, 32'h0000_0200);
        bus.ramstate = ACCESS;
        bus.ramload  = 32'hA5A5_0002;
        push_ack(1'b0, 32'hA5A5_0002);
        tick();
        bus.iREN     = 1'b0;
        bus.ramstate = FREE;
        tick();

        // dREN raised during IGRANT: no preemption, DGRANT two cycles after icache ACCESS
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h0000_0300;
        bus.ramstate = BUSY;
        tick();
        tick();
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h0000_0080;
        tick();
        chk32("nopreempt_ramaddr", bus.ramaddr, 32'h0000_0300);
        chk1("nopreempt_dwait", bus.dwait, 1'b1);
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h0BAD_F00D;
        push_ack(1'b0, 32'h0BAD_F00D);
        tick();
        bus.iREN     = 1'b0;
        bus.ramstate = BUSY;
        chk32("nopreempt_gap_ramaddr", bus.ramaddr, 32'h0);
        tick();
        chk1("nopreempt_dgrant_ramREN", bus.ramREN, 1'b1);
        chk32("nopreempt_dgrant_ramaddr", bus.ramaddr, 32'h0000_0080);
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h1357_9BDF;
        push_ack(1'b1, 32'h1357_9BDF);
        tick();
        bus.dREN     = 1'b0;
        bus.ramstate = FREE;
        tick();

        // request withdrawn mid-grant: back to IDLE, no acknowledge
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h0000_0400;
        bus.ramstate = BUSY;
        tick();
        bus.iREN     = 1'b0;
        tick();
        chk1("drop_ramREN", bus.ramREN, 1'b0);
        chk1("drop_iwait", bus.iwait, 1'b1);
        chk1("drop_tmo_err", tmo_err, 1'b0);
        bus.ramstate = FREE;
        tick();

        // ACCESS on the last allowed grant cycle wins over timeout
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h0000_0500;
        bus.ramstate = ERROR;
        tick();
        repeat (7) tick();
        chk1("edge_still_granted", bus.ramREN, 1'b1);
        bus.ramstate = ACCESS;
        bus.ramload  = 32'hFACE_0008;
        push_ack(1'b1, 32'hFACE_0008);
        tick();
        bus.dREN     = 1'b0;
        bus.ramstate = FREE;
        chk1("edge_tmo_err", tmo_err, 1'b0);
        tick();

        // RAM stuck in ERROR: timeout after 8 grant cycles, sticky tmo_err
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h0000_0600;
        bus.ramstate = ERROR;
        tick();
        for (int c = 2; c <= 8; c++) begin
            tick();
            chk1("tmo_grant_held", bus.ramREN, 1'b1);
        end
        chk1("tmo_err_before", tmo_err, 1'b0);
        tick();
        chk1("tmo_idle_ramREN", bus.ramREN, 1'b0);
        chk1("tmo_dwait", bus.dwait, 1'b1);
        chk1("tmo_err_set", tmo_err, 1'b1);
        bus.dREN     = 1'b0;
        bus.ramstate = FREE;
        repeat (3) tick();
        chk1("tmo_err_sticky", tmo_err, 1'b1);

`ifdef MEMCTRL_STATS_EN
        chk32("stats_dcount_pre", dcount, 32'(nd_exp));
        chk32("stats_icount_pre", icount, 32'(ni_exp));
`endif

        // reset pulse during a dcache write grant aborts it
        bus.dWEN     = 1'b1;
        bus.daddr    = 32'h0000_0700;
        bus.dstore   = 32'h7777_7777;
        bus.ramstate = BUSY;
        tick();
        chk1("pre_rst_ramWEN", bus.ramWEN, 1'b1);
        #2 nRST = 1'b0;
        #1;
        chk1("async_rst_ramWEN", bus.ramWEN, 1'b0);
        chk1("async_rst_ramREN", bus.ramREN, 1'b0);
        chk32("async_rst_ramaddr", bus.ramaddr, 32'h0);
        chk1("async_rst_dwait", bus.dwait, 1'b1);
        chk1("async_rst_tmo_err", tmo_err, 1'b0);
        bus.dWEN     = 1'b0;
        bus.ramstate = FREE;
        nd_exp = 0;
        ni_exp = 0;
        tick();
        nRST = 1'b1;
        tick();
        chk1("post_rst_ramREN", bus.ramREN, 1'b0);
        chk1("post_rst_dwait", bus.dwait, 1'b1);
`ifdef MEMCTRL_STATS_EN
        chk32("post_rst_dcount", dcount, 32'h0);
`endif

        // five dcache and three icache completed accesses
        for (int k = 0; k < 5; k++) begin
            d_txn(dv_wen[k], dv_addr[k], dv_data[k] ^ 32'hFFFF_FFFF, dv_data[k], 1 + (k % 3));
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            i_txn(iv_addr[k], iv_data[k], 1 + k);
            tick();
        end
`ifdef MEMCTRL_STATS_EN
        chk32("stats_dcount", dcount, 32'd5);
        chk32("stats_icount", icount, 32'd3);
`endif
        chk32("acks_issued_d", 32'(nd_exp), 32'd5);
        chk32("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
